// File: rtl/spram_fifo_stg.sv
// Synchronous FIFO on a single-port RAM. A one-entry write-staging register lets a write
// overlap a RAM read. The staged entry is flushed to the RAM on the next cycle with no read.
module spram_fifo_stg #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FIFO_DEPTH    = 32,
    parameter int unsigned ADDR_WIDTH    = $clog2(FIFO_DEPTH),
    parameter int unsigned AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int unsigned AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  wready,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  wr_err,
    output logic                  rd_err
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;
    localparam int unsigned DepthI = FIFO_DEPTH;
    localparam int unsigned AfullI = AFULL_THRESH;
    localparam int unsigned AemptyI = AEMPTY_THRESH;
    localparam logic [CntW-1:0] DepthC = DepthI[CntW-1:0];
    localparam logic [CntW-1:0] AfullC = AfullI[CntW-1:0];
    localparam logic [CntW-1:0] AemptyC = AemptyI[CntW-1:0];

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  stage_valid_q, stage_valid_d;
    logic [DATA_WIDTH-1:0] stage_data_q, stage_data_d;
    logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  rd_acc, wr_acc, ram_empty;
    logic                  ram_we, ram_re, bypass;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    assign empty        = (count_q == '0);
    assign full         = (count_q == DepthC);
    assign almost_full  = (count_q >= AfullC);
    assign almost_empty = (count_q <= AemptyC);
    assign count        = count_q;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;

    assign rd_acc    = ren && !empty;
    assign wready    = !full && !(stage_valid_q && rd_acc);
    assign wr_acc    = wen && wready;
    assign wr_err    = wen && !wready;
    assign rd_err    = ren && empty;
    // No RAM-resident entries: everything held (if anything) sits in staging.
    assign ram_empty = (count_q == {{ADDR_WIDTH{1'b0}}, stage_valid_q});

    always_comb begin
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        bypass        = 1'b0;
        ram_addr      = rd_ptr_q;
        ram_wdata     = wdata;
        stage_valid_d = stage_valid_q;
        stage_data_d  = stage_data_q;
        stage_addr_d  = stage_addr_q;

        if (rd_acc && !ram_empty) begin
            ram_re = 1'b1;
            if (wr_acc) begin
                stage_valid_d = 1'b1;
                stage_data_d  = wdata;
                stage_addr_d  = wr_ptr_q;
            end
        end else if (rd_acc) begin
            bypass        = 1'b1;
            stage_valid_d = 1'b0;
            if (wr_acc) begin
                ram_we   = 1'b1;
                ram_addr = wr_ptr_q;
            end
        end else if (stage_valid_q) begin
            ram_we    = 1'b1;
            ram_addr  = stage_addr_q;
            ram_wdata = stage_data_q;
            if (wr_acc) begin
                stage_data_d = wdata;
                stage_addr_d = wr_ptr_q;
            end else begin
                stage_valid_d = 1'b0;
            end
        end else if (wr_acc) begin
            ram_we   = 1'b1;
            ram_addr = wr_ptr_q;
        end
    end

    always_comb begin
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDR_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDR_WIDTH'(1) : rd_ptr_q;
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CntW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            stage_valid_q <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            stage_valid_q <= stage_valid_d;
            rvalid_q      <= rd_acc;
            if (ram_re) begin
                rdata_q <= mem[ram_addr];
            end else if (bypass) begin
                rdata_q <= stage_data_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        stage_data_q <= stage_data_d;
        stage_addr_q <= stage_addr_d;
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ram_we && ram_re));
        end
    end

endmodule

// File: tb/tb_spram_fifo_stg.sv
// Scoreboard bench for spram_fifo_stg: a queue-based reference model predicts flags and
// acceptance each cycle; a separate monitor checks every rvalid against expected read data.
module tb_spram_fifo_stg;

    localparam int DW = 8;
    localparam int DEPTH = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic [DW-1:0] wdata = '0;
    logic          ren = 1'b0;
    logic          wready, full, almost_full, rvalid, empty, almost_empty, wr_err, rd_err;
    logic [DW-1:0] rdata;
    logic [AW:0]   count;

    spram_fifo_stg dut (
        .clk          (clk),
        .rst          (rst),
        .wen          (wen),
        .wdata        (wdata),
        .wready       (wready),
        .full         (full),
        .almost_full  (almost_full),
        .ren          (ren),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count),
        .wr_err       (wr_err),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    bit   run = 1'b0;
    exp_t exp_q[$];
    int   model_q[$];   // entries held, oldest first
    bit   newest_staged; // newest entry not yet in RAM
    bit   last_wacc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc - 1) begin
                chk("rvalid", 32'(rvalid), 32'd1);
                chk("rdata", 32'(rdata), 32'(exp_q[0].data));
                void'(exp_q.pop_front());
            end else begin
                chk("rvalid_idle", 32'(rvalid), 32'd0);
            end
        end
    end

    // One clock cycle: drive, check against the model, advance the model.
    task automatic step(input bit w, input int d, input bit r, input bit rs = 1'b0);
        int cnt, held_in_ram;
        bit e_empty, e_wready, racc, wacc;
        wen   = w;
        wdata = DW'(d);
        ren   = r;
        rst   = rs;
        #2;
        cnt         = model_q.size();
        held_in_ram = cnt - int'(newest_staged);
        e_empty     = (cnt == 0);
        racc        = r && !e_empty;
        e_wready    = (cnt != DEPTH) && !(newest_staged && racc);
        wacc        = w && e_wready;
        chk("count", 32'(count), 32'(cnt));
        chk("empty", 32'(empty), 32'(e_empty));
        chk("full", 32'(full), 32'(cnt == DEPTH));
        chk("almost_full", 32'(almost_full), 32'(cnt >= DEPTH - 4));
        chk("almost_empty", 32'(almost_empty), 32'(cnt <= 4));
        chk("wready", 32'(wready), 32'(e_wready));
        chk("wr_err", 32'(wr_err), 32'(w && !e_wready));
        chk("rd_err", 32'(rd_err), 32'(r && e_empty));
        last_wacc = wacc;
        if (rs) begin
            model_q.delete();
            newest_staged = 1'b0;
        end else begin
            // A write lands in staging when the port is busy reading the RAM, or when
            // staging is already occupied and being flushed. Idle cycles flush it.
            if (wacc && racc)       newest_staged = 1'b1;
            else if (wacc)          newest_staged = newest_staged;
            else if (racc)          newest_staged = newest_staged && (held_in_ram > 0);
            else                    newest_staged = 1'b0;
            if (racc) begin
                exp_q.push_back('{data: model_q[0], cyc: cyc});
                void'(model_q.pop_front());
            end
            if (wacc) model_q.push_back(d & 8'hFF);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nxt, guard, pw, pr;
        newest_staged = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;

        // Reset state, then fill to full and overflow.
        step(0, 0, 0);
        for (int i = 1; i <= 32; i++) step(1, i, 0);
        step(1, 33, 0);
        step(0, 0, 0);
        chk("full_count", 32'(count), 32'd32);

        // Drain all 32, then underflow.
        for (int i = 0; i < 32; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0);

        // Preload 1..3, then continuous write+read of 4..8.
        for (int i = 1; i <= 3; i++) step(1, i, 0);
        nxt = 4;
        guard = 0;
        while ((nxt <= 8 || model_q.size() > 0) && guard < 60) begin
            step(nxt <= 8, nxt, model_q.size() > 0);
            if (last_wacc) nxt++;
            guard++;
        end
        chk("stream_done", 32'(guard < 60), 32'd1);
        step(0, 0, 0);

        // Bypass of the staged entry.
        step(1, 'h11, 0);
        step(1, 'h22, 1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("bypass_empty", 32'(empty), 32'd1);

        // Reset while staging is occupied and a read is in flight.
        step(1, 'hA1, 0);
        step(1, 'hA2, 0);
        step(1, 'hA3, 1);
        step(0, 0, 1, 1'b1);
        step(0, 0, 0);
        step(1, 'h5A, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        // Randomised traffic in phases of different write/read bias.
        for (int ph = 0; ph < 6; ph++) begin
            pw = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 30 : 55;
            pr = (ph % 3 == 0) ? 30 : (ph % 3 == 1) ? 80 : 55;
            for (int k = 0; k < 150; k++) begin
                step($urandom_range(0, 99) < pw, int'($urandom_range(0, 255)),
                     $urandom_range(0, 99) < pr);
            end
        end
        step(0, 0, 0);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
